// File: rtl/averager_pkg.sv
// Shared defaults, channel-tag width helper and the per-channel state record
// for the multi-channel moving averager.
package averager_pkg;

  localparam int unsigned N_DEFAULT         = 12;
  localparam int unsigned MAX_POWER_DEFAULT = 8;
  localparam int unsigned CH_DEFAULT        = 4;

  function automatic int unsigned ch_width(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // Record layout at the default sizes; the top declares the same layout
  // sized from its own parameters.
  typedef struct packed {
    logic [N_DEFAULT+MAX_POWER_DEFAULT-1:0] sum;
    logic [MAX_POWER_DEFAULT-1:0]           wr_ptr;
    logic [MAX_POWER_DEFAULT:0]             fill;
  } avg_state_t;

endpackage

// File: rtl/avg_hist_ram.sv
// Sample history for all channels: synchronous write, asynchronous read,
// addressed by {channel, pointer}. Contents are never reset.
module avg_hist_ram #(
  parameter int unsigned W     = 12,
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/averager_multi.sv
// Multi-channel moving averager over a runtime window of 2**win_pow samples.
// Define AVERAGER_ROUND_EN for round-half-up output; default build truncates.
module averager_multi
  import averager_pkg::*;
#(
  parameter  int unsigned N         = N_DEFAULT,
  parameter  int unsigned MAX_POWER = MAX_POWER_DEFAULT,
  parameter  int unsigned CH        = CH_DEFAULT,
  localparam int unsigned CH_W      = ch_width(CH),
  localparam int unsigned WP_W      = $clog2(MAX_POWER + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WP_W-1:0] win_pow,
  input  logic            flush,
  input  logic            din_valid,
  input  logic [CH_W-1:0] din_ch,
  input  logic [N-1:0]    din,
  output logic            q_valid,
  output logic [CH_W-1:0] q_ch,
  output logic [N-1:0]    q,
  output logic [CH-1:0]   full
);

  localparam int unsigned SUM_W = N + MAX_POWER;
  localparam int unsigned AW    = CH_W + MAX_POWER;
  localparam logic [MAX_POWER:0]   FILL_ONE = 1;
  localparam logic [MAX_POWER-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic [SUM_W-1:0]     sum;
    logic [MAX_POWER-1:0] wr_ptr;
    logic [MAX_POWER:0]   fill;
  } chan_state_t;

  chan_state_t          st_q [CH];
  chan_state_t          st_d [CH];
  chan_state_t          cur;
  logic [CH-1:0]        full_q, full_d;
  logic [WP_W-1:0]      wp_q, wp_eff;
  logic                 q_valid_q, q_valid_d;
  logic [CH_W-1:0]      q_ch_q, q_ch_d;
  logic [N-1:0]         q_q, q_d;
  logic                 ch_ok, flush_eff, accept, win_full;
  logic [MAX_POWER:0]   win_size, fill_new;
  logic [MAX_POWER-1:0] rd_ptr;
  logic [N-1:0]         hist_rd, oldest;
  logic [SUM_W-1:0]     sum_new;

  if (CH == (1 << CH_W)) begin : g_ch_full_range
    assign ch_ok = 1'b1;
  end else begin : g_ch_partial_range
    assign ch_ok = (din_ch < CH_W'(CH));
  end

  assign wp_eff    = (win_pow > WP_W'(MAX_POWER)) ? WP_W'(MAX_POWER) : win_pow;
  // A change of the (clamped) window exponent discards all history.
  assign flush_eff = flush | (wp_eff != wp_q);
  assign accept    = din_valid & ch_ok & ~flush_eff;

  assign win_size = FILL_ONE << wp_eff;
  assign cur      = st_q[din_ch];
  assign win_full = (cur.fill == win_size);
  // Window of 2**MAX_POWER points at the slot about to be overwritten.
  assign rd_ptr   = cur.wr_ptr - win_size[MAX_POWER-1:0];
  assign oldest   = win_full ? hist_rd : '0;
  assign sum_new  = cur.sum + SUM_W'(din) - SUM_W'(oldest);
  assign fill_new = win_full ? cur.fill : cur.fill + FILL_ONE;

  avg_hist_ram #(
    .W     (N),
    .AW    (AW),
    .DEPTH (CH << MAX_POWER)
  ) u_hist (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i ({din_ch, cur.wr_ptr}),
    .wdata_i (din),
    .raddr_i ({din_ch, rd_ptr}),
    .rdata_o (hist_rd)
  );

`ifdef AVERAGER_ROUND_EN
  localparam logic [SUM_W:0] ROUND_ONE = 1;
  logic [SUM_W:0] rnd_sum, rnd_shift;

  always_comb begin
    rnd_sum = {1'b0, sum_new};
    if (wp_eff != '0) rnd_sum = {1'b0, sum_new} + (ROUND_ONE << (wp_eff - WP_W'(1)));
    rnd_shift = rnd_sum >> wp_eff;
  end
`endif

  always_comb begin
    st_d      = st_q;
    full_d    = full_q;
    q_valid_d = accept;
    q_ch_d    = q_ch_q;
    q_d       = q_q;
    if (flush_eff) begin
      for (int unsigned c = 0; c < CH; c++) st_d[c] = '0;
      full_d = '0;
    end else if (accept) begin
      st_d[din_ch].sum    = sum_new;
      st_d[din_ch].wr_ptr = cur.wr_ptr + PTR_ONE;
      st_d[din_ch].fill   = fill_new;
      full_d[din_ch]      = (fill_new == win_size);
      q_ch_d              = din_ch;
`ifdef AVERAGER_ROUND_EN
      q_d = (|rnd_shift[SUM_W:N]) ? '1 : rnd_shift[N-1:0];
`else
      q_d = N'(sum_new >> wp_eff);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned c = 0; c < CH; c++) st_q[c] <= '0;
      full_q    <= '0;
      wp_q      <= '0;
      q_valid_q <= 1'b0;
      q_ch_q    <= '0;
      q_q       <= '0;
    end else begin
      st_q      <= st_d;
      full_q    <= full_d;
      wp_q      <= wp_eff;
      q_valid_q <= q_valid_d;
      q_ch_q    <= q_ch_d;
      q_q       <= q_d;
    end
  end

  assign q_valid = q_valid_q;
  assign q_ch    = q_ch_q;
  assign q       = q_q;
  assign full    = full_q;

endmodule

// File: tb/tb_averager_multi.sv
// Bench for averager_multi: table of samples with expected window sums, a
// scoreboard queue of expected results, and hand-written corner sequences.
module tb_averager_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  win_pow;
  logic        flush;
  logic        din_valid;
  logic [1:0]  din_ch;
  logic [11:0] din;
  logic        q_valid;
  logic [1:0]  q_ch;
  logic [11:0] q;
  logic [3:0]  full;

  averager_multi dut (
    .clk       (clk),
    .reset     (reset),
    .win_pow   (win_pow),
    .flush     (flush),
    .din_valid (din_valid),
    .din_ch    (din_ch),
    .din       (din),
    .q_valid   (q_valid),
    .q_ch      (q_ch),
    .q         (q),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned wp;
    int unsigned ch;
    int unsigned din;
    int unsigned sum;
    logic [3:0]  full;
  } vec_t;

  typedef struct {
    int unsigned ch;
    int unsigned q;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_avg(input longint unsigned sum, input int unsigned wp);
    longint unsigned r;
`ifdef AVERAGER_ROUND_EN
    if (wp == 0) r = sum;
    else r = (sum + (64'd1 << (wp - 1))) >> wp;
    if (r > 4095) r = 4095;
`else
    r = sum >> wp;
`endif
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned ch, input int unsigned val,
                      input int unsigned exp_q);
    exp_t e;
    din_valid = 1'b1;
    din_ch    = 2'(ch);
    din       = 12'(val);
    e.ch = ch;
    e.q  = exp_q;
    sb.push_back(e);
    step();
    din_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q_valid === 1'b1) begin
      exp_t e;
      check("result_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q_ch", q_ch, e.ch);
        check("q", q, e.q);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  vec_t        tbl[26];
  int unsigned cur_wp;

  initial begin
    tbl[0] = '{2, 0, 4, 4, 4'b0000};
    tbl[1] = '{2, 0, 8, 12, 4'b0000};
    tbl[2] = '{2, 0, 12, 24, 4'b0000};
    tbl[3] = '{2, 0, 16, 40, 4'b0001};
    tbl[4] = '{2, 0, 20, 56, 4'b0001};
    for (int k = 1; k <= 8; k++) begin
      tbl[3 + 2*k] = '{3, 1, 100, 100*k, (k == 8) ? 4'b0010 : 4'b0000};
      tbl[4 + 2*k] = '{3, 2, 200, 200*k, (k == 8) ? 4'b0110 : 4'b0000};
    end
    tbl[21] = '{2, 0, 40, 40, 4'b0000};
    tbl[22] = '{2, 0, 40, 80, 4'b0000};
    tbl[23] = '{3, 0, 80, 80, 4'b0000};
    tbl[24] = '{0, 3, 7, 7, 4'b1000};
    tbl[25] = '{0, 3, 9, 9, 4'b1000};

    reset = 1'b1; win_pow = '0; flush = 1'b0;
    din_valid = 1'b0; din_ch = '0; din = '0;
    step(); step();
    check("reset_q_valid", q_valid, 0);
    check("reset_q", q, 0);
    check("reset_q_ch", q_ch, 0);
    check("reset_full", full, 0);
    reset = 1'b0;
    cur_wp = 0;

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].wp != cur_wp) begin
        win_pow = 4'(tbl[i].wp);
        cur_wp  = tbl[i].wp;
        step();
      end
      send(tbl[i].ch, tbl[i].din, exp_avg(tbl[i].sum, tbl[i].wp));
      check($sformatf("full_vec%0d", i), full, tbl[i].full);
    end

    // flush and a sample in the same cycle: sample dropped
    win_pow = 4'd1;
    step();
    flush = 1'b1; din_valid = 1'b1; din_ch = 2'd0; din = 12'd10;
    step();
    flush = 1'b0; din_valid = 1'b0;
    check("flush_wins_q_valid", q_valid, 0);
    send(0, 64, exp_avg(64, 1));
    check("after_flush_full", full, 0);

    // explicit flush pulse, then a rounding-sensitive sample
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_pulse_full", full, 0);
    send(0, 3, exp_avg(3, 1));

    // all-ones over the largest window, then an over-range win_pow
    win_pow = 4'd8;
    step();
    for (int k = 1; k <= 256; k++) send(2, 4095, exp_avg(64'(k) * 4095, 8));
    check("max_window_full", full, 4'b0100);
    win_pow = 4'd15;
    send(2, 4095, exp_avg(256 * 4095, 8));
    check("clamped_full", full, 4'b0100);

    // reset in the same cycle as a sample cancels its result
    win_pow = 4'd1;
    step();
    send(1, 50, exp_avg(50, 1));
    reset = 1'b1; din_valid = 1'b1; din_ch = 2'd1; din = 12'd70;
    step();
    reset = 1'b0; din_valid = 1'b0;
    check("midreset_q_valid", q_valid, 0);
    check("midreset_q", q, 0);
    check("midreset_full", full, 0);
    step();
    send(1, 64, exp_avg(64, 1));
    check("post_reset_full", full, 0);

    step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/averager_multi.md
AVERAGER_MULTI -- requirements
Module: averager_multi

Interface
REQ-001 Parameter N, default 12: bit width of each input sample and of the average.
REQ-002 Parameter MAX_POWER, default 8: the largest window is 2**MAX_POWER samples per channel.
REQ-003 Parameter CH, default 4: number of independent channels; CH_W = max(1, clog2(CH)).
REQ-004 Port clk, input, 1: single clock; all logic is on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port win_pow, input, clog2(MAX_POWER+1): runtime window exponent; the window is 2**win_pow samples; values above MAX_POWER are clamped to MAX_POWER.
REQ-007 Port flush, input, 1: a one-cycle pulse that clears the history and sums of all channels.
REQ-008 Port din_valid, input, 1: sample strobe, equivalent to the former EN.
REQ-009 Port din_ch, input, CH_W: channel tag of the sample.
REQ-010 Port din, input, N: unsigned sample.
REQ-011 Port q_valid, output, 1: one-cycle result strobe.
REQ-012 Port q_ch, output, CH_W: channel of the result.
REQ-013 Port q, output, N: moving average of channel q_ch.
REQ-014 Port full, output, CH: per-channel flag, high once the channel holds 2**win_pow samples.

Function
REQ-015 Each channel shall keep a circular history of depth 2**MAX_POWER, a write pointer, a fill counter saturating at 2**win_pow, and a running sum of N+MAX_POWER bits.
REQ-016 An accepted sample (din_valid high, din_ch < CH, no flush) shall update only channel din_ch: sum <= sum + din - oldest.
REQ-017 The value oldest shall be history[wr_ptr - 2**win_pow mod 2**MAX_POWER] when the fill counter has reached 2**win_pow; otherwise oldest is 0.
REQ-018 After each accepted sample, din shall be written at wr_ptr and wr_ptr shall increment, wrapping from 2**MAX_POWER-1 to 0.
REQ-019 Latency shall be one cycle: q_valid, q_ch and q register in the cycle after acceptance and reflect the updated sum.
REQ-020 The output q shall be (updated sum) >> win_pow, truncated to N bits (or rounded, see REQ-030).
REQ-021 The output q_valid shall be high for exactly one cycle per accepted sample, with no backpressure; a new sample may arrive every cycle, including on the same channel back to back.
REQ-022 While a channel is filling, q shall be sum >> win_pow, i.e. zero-padded and ramping up; full[c] shall rise in the cycle that q_valid reports the 2**win_pow-th sample.
REQ-023 A change of win_pow between consecutive cycles shall act as an implicit flush, detected by comparing against a registered copy of win_pow.
REQ-024 A flush, explicit or implicit, shall zero all sums, fill counters, write pointers and full flags; the history contents need not be cleared.
REQ-025 When flush and din_valid occur in the same cycle, flush shall win: the sample is discarded and q_valid is 0 in the next cycle.
REQ-026 A sample with din_ch >= CH shall be ignored: no state change and no q_valid.
REQ-027 With win_pow = 0, q shall equal the last din of that channel.

Reset
REQ-028 Reset shall behave as a flush and additionally clear q_valid, q_ch, q and the registered win_pow, all to 0.
REQ-029 Reset asserted mid-stream shall cancel any pending q_valid; the first sample after reset release is treated as sample 1.

Configuration
REQ-030 The macro AVERAGER_ROUND_EN controls output rounding:
- Defined: q = (sum + 2**(win_pow-1)) >> win_pow, saturated to 2**N-1, and no rounding when win_pow = 0.
- Undefined: q is truncated as in REQ-020.

Structure
REQ-031 A package averager_pkg shall hold the defaults for N, MAX_POWER and CH, the CH_W function, and a typedef for the per-channel state record (sum, wr_ptr, fill).
REQ-032 The history shall live in one sub-module avg_hist_ram: one synchronous-write, asynchronous-read array of depth CH*2**MAX_POWER, addressed by {channel, pointer}.
REQ-033 Everything else shall reside in averager_multi.

Verification
REQ-034 Defaults, win_pow = 2, channel 0 fed 4, 8, 12, 16 -> q = 1, 3, 6, 10; full[0] rises with the 4th result.
REQ-035 win_pow = 2, channel 0 then fed 20 -> q = 14, since 4 is evicted.
REQ-036 Interleave channel 1 = 100 and channel 2 = 200 every cycle for 8 cycles with win_pow = 3 -> the final q is 100 and 200 respectively, with no cross-channel contamination.
REQ-037 Change win_pow from 2 to 3 mid-stream, then feed 80 -> q = 10 and all full bits are 0.
REQ-038 Assert flush and din_valid in the same cycle -> no q_valid follows; the next sample 64 with win_pow = 1 gives q = 32.
REQ-039 With AVERAGER_ROUND_EN, win_pow = 1, channel 0 fed 3 -> q = 2 (truncated build gives 1); all-ones samples with win_pow = MAX_POWER -> q = 4095, with no overflow.
